// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
package fifo_pkg;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake, data and status bundle between a FIFO and its producer/consumer.
interface sync_fifo_param_if
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_WIDTH = 32
);
   localparam int CNT_W = addr_w(FIFO_DEPTH) + 1;

   logic                  push;
   logic                  pop;
   logic                  clr_err;
   logic [FIFO_WIDTH-1:0] data_in;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output push, pop, clr_err, data_in,
      input  data_out, fifo_full, fifo_empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  push, pop, clr_err, data_in,
      output data_out, fifo_full, fifo_empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag control for the synchronous FIFO.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   localparam int ADDR_W    = addr_w(FIFO_DEPTH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   output logic              push_ok,
   output logic              pop_ok,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   count,
   output fifo_status_t      status
);
   typedef logic [ADDR_W:0] ptr_t;

   localparam ptr_t AF_CNT = ptr_t'(AF_LEVEL);
   localparam ptr_t AE_CNT = ptr_t'(AE_LEVEL);

   ptr_t wr_ptr;
   ptr_t rd_ptr;
   logic full;
   logic empty;

   // Extra MSB on each pointer separates "same slot, lapped" (full) from "same slot" (empty).
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign wr_addr = wr_ptr[ADDR_W-1:0];
   assign rd_addr = rd_ptr[ADDR_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      status              = '0;
      status.full         = full;
      status.empty        = empty;
      status.almost_full  = (count >= AF_CNT);
      status.almost_empty = (count <= AE_CNT);
   end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: indexed storage, show-ahead read and sticky error flags.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_WIDTH = 32,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1
)(
   input logic               clk,
   input logic               reset,
   sync_fifo_param_if.slave  bus
);
   localparam int ADDR_W = addr_w(FIFO_DEPTH);

   if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
      $fatal(1, "sync_fifo_param: FIFO_DEPTH=%0d must be a power of 2 and >= 2", FIFO_DEPTH);
   end
   if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
      $fatal(1, "sync_fifo_param: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, FIFO_DEPTH);
   end
   if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
      $fatal(1, "sync_fifo_param: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, FIFO_DEPTH - 1);
   end

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic                  push_ok;
   logic                  pop_ok;
   logic [ADDR_W-1:0]     wr_addr;
   logic [ADDR_W-1:0]     rd_addr;
   logic [ADDR_W:0]       count;
   fifo_status_t          status;
   logic                  overflow;
   logic                  underflow;

   fifo_ptr_ctrl #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
   ) u_ptr_ctrl (
      .clk     (clk),
      .reset   (reset),
      .push    (bus.push),
      .pop     (bus.pop),
      .push_ok (push_ok),
      .pop_ok  (pop_ok),
      .wr_addr (wr_addr),
      .rd_addr (rd_addr),
      .count   (count),
      .status  (status)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wr_addr] <= bus.data_in;
      end
   end

   // Set takes priority over clear so an error in the clearing cycle is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (bus.push && status.full)  || (overflow  && !bus.clr_err);
         underflow <= (bus.pop  && status.empty) || (underflow && !bus.clr_err);
      end
   end

   assign bus.data_out     = status.empty ? '0 : mem[rd_addr];
   assign bus.fifo_full    = status.full;
   assign bus.fifo_empty   = status.empty;
   assign bus.almost_full  = status.almost_full;
   assign bus.almost_empty = status.almost_empty;
   assign bus.count        = count;
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;
endmodule
